// File: rtl/banked_memory_pkg.sv
// -----------------------------------------------------------------------------
// banked_memory_pkg
// Shared definitions for the banked memory: address split helpers (bank index
// and row), byte-strobe width derivation and the per-port request record.
// The request record is sized for the widest supported configuration; the top
// level zero-extends its ports into it and truncates back on use.
// -----------------------------------------------------------------------------
package banked_memory_pkg;

    localparam int unsigned MaxAddrWidth = 32;
    localparam int unsigned MaxDataWidth = 128;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic                    we;
        logic [MaxStrbWidth-1:0] strb;
        logic [MaxDataWidth-1:0] wdata;
    } req_t;

    function automatic int unsigned strb_width(int unsigned data_width);
        return data_width / 8;
    endfunction

    // Low address bits select the bank (word interleaving).
    function automatic int unsigned bank_of(logic [MaxAddrWidth-1:0] addr,
                                            int unsigned bank_bits);
        return addr & ((MaxAddrWidth'(1) << bank_bits) - MaxAddrWidth'(1));
    endfunction

    // Remaining high bits select the row inside the bank.
    function automatic int unsigned row_of(logic [MaxAddrWidth-1:0] addr,
                                           int unsigned bank_bits);
        return addr >> bank_bits;
    endfunction

endpackage

// File: rtl/banked_memory_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Priority starts at the pointer and rises with port
// index, wrapping around. On a grant the pointer moves just past the winner;
// with no grant it holds.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (pointer -> 0)
//   req_i  : request vector
//   gnt_o  : one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrWidth-1:0] ptr_q, ptr_d;
    logic                found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        // First pass: requesters at or above the pointer.
        for (int i = 0; i < int'(NumReq); i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Second pass: wrap around to the lowest index.
        for (int i = 0; i < int'(NumReq); i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < int'(NumReq); i++) begin
            if (gnt_o[i]) begin
                ptr_d = (i == int'(NumReq) - 1) ? '0 : PtrWidth'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/banked_memory.sv
// -----------------------------------------------------------------------------
// banked_memory
// Multi-port, word-interleaved memory built from NumBanks single-port banks.
// Each bank has its own round-robin arbiter; ports hitting different banks are
// served in the same cycle. Reads return data one cycle after acceptance,
// writes are byte-strobed and acknowledged with a zero-data response.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   req_valid_i  : per-port request valid
//   req_ready_o  : per-port accept (granted its target bank this cycle)
//   req_addr_i   : per-port word address
//   req_we_i     : per-port write enable (1 = write)
//   req_strb_i   : per-port byte write enables
//   req_wdata_i  : per-port write data
//   rsp_valid_o  : per-port response pulse, one cycle after acceptance
//   rsp_rdata_o  : per-port read data (0 for write acks, held otherwise)
// -----------------------------------------------------------------------------
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned NumBanks  = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned DataDepth = 4096,
    parameter int unsigned StrbWidth = strb_width(DataWidth),
    parameter int unsigned AddrWidth = $clog2(DataDepth)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumPorts-1:0]                 req_valid_i,
    output logic [NumPorts-1:0]                 req_ready_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NumPorts-1:0]                 req_we_i,
    input  logic [NumPorts-1:0][StrbWidth-1:0]  req_strb_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata_i,
    output logic [NumPorts-1:0]                 rsp_valid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]  rsp_rdata_o
);

    localparam int unsigned BankBits  = $clog2(NumBanks);
    localparam int unsigned BankIdxW  = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned RowWidth  = (AddrWidth > BankBits) ? AddrWidth - BankBits : 1;
    localparam int unsigned BankDepth = DataDepth / NumBanks;

    if (NumBanks == 0 || (NumBanks & (NumBanks - 1)) != 0) begin : g_chk_banks
        $error("NumBanks must be a power of two");
    end
    if (DataDepth % NumBanks != 0) begin : g_chk_depth
        $error("DataDepth must be divisible by NumBanks");
    end
    if (DataWidth % 8 != 0 || DataWidth > MaxDataWidth) begin : g_chk_width
        $error("DataWidth must be a multiple of 8 and fit the request record");
    end
    if (NumPorts < 1) begin : g_chk_ports
        $error("NumPorts must be at least 1");
    end

    req_t                  req      [NumPorts];
    logic [BankIdxW-1:0]   bank_sel [NumPorts];
    logic [RowWidth-1:0]   row_sel  [NumPorts];
    logic [DataWidth-1:0]  bank_rdata [NumBanks];
    logic [NumPorts-1:0]   bank_gnt   [NumBanks];

    logic [NumPorts-1:0]                rsp_valid_q, rsp_valid_d;
    logic [NumPorts-1:0][DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            req[p].addr  = MaxAddrWidth'(req_addr_i[p]);
            req[p].we    = req_we_i[p];
            req[p].strb  = MaxStrbWidth'(req_strb_i[p]);
            req[p].wdata = MaxDataWidth'(req_wdata_i[p]);
            bank_sel[p]  = BankIdxW'(bank_of(req[p].addr, BankBits));
            row_sel[p]   = RowWidth'(row_of(req[p].addr, BankBits));
        end
    end

    for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
        logic [NumPorts-1:0]  req_vec;
        logic [NumPorts-1:0]  gnt;
        logic [RowWidth-1:0]  row;
        logic                 we;
        logic [StrbWidth-1:0] strb;
        logic [DataWidth-1:0] wdata;
        logic [DataWidth-1:0] mem [BankDepth];

        // Requests are masked during reset so no grant (and no write) can occur.
        always_comb begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                req_vec[p] = req_valid_i[p] && (bank_sel[p] == BankIdxW'(b)) && !rst_i;
            end
        end

        rr_arbiter #(.NumReq(NumPorts)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (req_vec),
            .gnt_o (gnt)
        );

        // Steer the winner's request onto the bank's single port.
        always_comb begin
            row   = '0;
            we    = 1'b0;
            strb  = '0;
            wdata = '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                if (gnt[p]) begin
                    row   = row_sel[p];
                    we    = req[p].we;
                    strb  = StrbWidth'(req[p].strb);
                    wdata = DataWidth'(req[p].wdata);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if ((|gnt) && we) begin
                for (int i = 0; i < int'(StrbWidth); i++) begin
                    if (strb[i]) begin
                        mem[row][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end

        // Pre-write contents; captured into the response register at the edge.
        assign bank_rdata[b] = mem[row];
        assign bank_gnt[b]   = gnt;
    end

    always_comb begin
        req_ready_o = '0;
        for (int b = 0; b < int'(NumBanks); b++) begin
            req_ready_o = req_ready_o | bank_gnt[b];
        end
    end

    always_comb begin
        rsp_valid_d = req_ready_o;
        rsp_rdata_d = rsp_rdata_q;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (req_ready_o[p]) begin
                rsp_rdata_d[p] = req[p].we ? '0 : bank_rdata[bank_sel[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // A response due in a reset cycle is suppressed, so a request accepted just
    // before reset never produces a visible pulse.
    assign rsp_valid_o = rsp_valid_q & ~{NumPorts{rst_i}};
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_banked_memory.sv
module tb_banked_memory;

    localparam int NP = 2;
    localparam int NB = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]         req_valid, req_ready, req_we, rsp_valid;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][SW-1:0] req_strb;
    logic [NP-1:0][DW-1:0] req_wdata, rsp_rdata;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic [DW-1:0] mm [int];
    int            ptr_m [NB];
    logic [NP-1:0] exp_v;
    logic [DW-1:0] exp_d [NP];

    always #5 clk = ~clk;

    banked_memory dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_strb_i  (req_strb),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(int p, logic v, int a, logic we, logic [SW-1:0] s, logic [DW-1:0] d);
        req_valid[p] = v;
        req_addr[p]  = AW'(a);
        req_we[p]    = we;
        req_strb[p]  = s;
        req_wdata[p] = d;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 0, 1'b0, '0, '0);
    endtask

    // One clock: at the falling edge compare the DUT with the model, then
    // advance the model to what the next rising edge must produce.
    task automatic tick();
        int            win [NB];
        logic [NP-1:0] er;
        int            a;
        @(negedge clk);
        er = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            if (!rst) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (ptr_m[b] + k) % NP;
                    if (win[b] < 0 && req_valid[p] && (int'(req_addr[p]) % NB) == b) win[b] = p;
                end
            end
            if (win[b] >= 0) er[win[b]] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), rst ? 64'd0 : 64'(exp_v));
        for (int p = 0; p < NP; p++)
            chk($sformatf("rsp_rdata[%0d]", p), 64'(rsp_rdata[p]), 64'(exp_d[p]));
        if (rst) begin
            exp_v = '0;
            for (int p = 0; p < NP; p++) exp_d[p] = '0;
            for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        end else begin
            exp_v = er;
            for (int p = 0; p < NP; p++) begin
                if (er[p]) begin
                    a = int'(req_addr[p]);
                    exp_d[p] = req_we[p] ? '0 : (mm.exists(a) ? mm[a] : 'x);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (er[p] && req_we[p]) begin
                    a = int'(req_addr[p]);
                    if (!mm.exists(a)) mm[a] = '0;
                    for (int k = 0; k < SW; k++)
                        if (req_strb[p][k]) mm[a][8*k +: 8] = req_wdata[p][8*k +: 8];
                end
            end
            for (int b = 0; b < NB; b++)
                if (win[b] >= 0) ptr_m[b] = (win[b] + 1) % NP;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NP-1:0] conflict_gnt [4];
        conflict_gnt[0] = 2'b01; conflict_gnt[1] = 2'b10;
        conflict_gnt[2] = 2'b01; conflict_gnt[3] = 2'b10;
        exp_v = '0;
        for (int p = 0; p < NP; p++) exp_d[p] = '0;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        rst = 1'b1;
        clear_reqs();
        set_req(0, 1'b1, 0, 1'b0, '0, '0);

        // Reset state
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata0", 64'(rsp_rdata[0]), 64'd0);
        rst = 1'b0;
        clear_reqs();
        tick();

        // Write then back-to-back read
        set_req(0, 1'b1, 5, 1'b1, 4'b1111, 32'h11223344);
        #1 chk("t1_wr_ready", 64'(req_ready), 64'b01);
        tick();
        chk("t1_wr_ack_valid", 64'(rsp_valid), 64'b01);
        chk("t1_wr_ack_data", 64'(rsp_rdata[0]), 64'd0);
        set_req(0, 1'b1, 5, 1'b0, '0, '0);
        #1 chk("t1_rd_ready", 64'(req_ready), 64'b01);
        tick();
        chk("t1_rd_data", 64'(rsp_rdata[0]), 64'h11223344);

        // Partial strobe
        set_req(0, 1'b1, 8, 1'b1, 4'b1111, 32'hAABBCCDD);
        tick();
        set_req(0, 1'b1, 8, 1'b1, 4'b0001, 32'h00000011);
        tick();
        set_req(0, 1'b1, 8, 1'b0, '0, '0);
        tick();
        chk("t2_partial", 64'(rsp_rdata[0]), 64'hAABBCC11);

        // Zero strobe write is acknowledged and changes nothing
        set_req(0, 1'b1, 5, 1'b1, 4'b0000, 32'hFFFFFFFF);
        tick();
        chk("strb0_ack", 64'(rsp_valid), 64'b01);
        set_req(0, 1'b1, 5, 1'b0, '0, '0);
        tick();
        chk("strb0_data", 64'(rsp_rdata[0]), 64'h11223344);

        // Parallel access to banks 0 and 1
        set_req(0, 1'b1, 4, 1'b1, 4'b1111, 32'h44444444);
        set_req(1, 1'b1, 5, 1'b1, 4'b1111, 32'h55555555);
        #1 chk("t3_wr_ready", 64'(req_ready), 64'b11);
        tick();
        set_req(0, 1'b1, 4, 1'b0, '0, '0);
        set_req(1, 1'b1, 5, 1'b0, '0, '0);
        #1 chk("t3_rd_ready", 64'(req_ready), 64'b11);
        tick();
        chk("t3_rsp_valid", 64'(rsp_valid), 64'b11);
        chk("t3_rdata0", 64'(rsp_rdata[0]), 64'h44444444);
        chk("t3_rdata1", 64'(rsp_rdata[1]), 64'h55555555);

        // Preload addr 0 and 3 (banks 0 and 3)
        set_req(0, 1'b1, 0, 1'b1, 4'b1111, 32'h0A0A0A0A);
        set_req(1, 1'b1, 3, 1'b1, 4'b1111, 32'h33333333);
        tick();
        clear_reqs();

        // Reset mid-operation
        set_req(0, 1'b1, 3, 1'b0, '0, '0);
        #1 chk("t5_pre_ready", 64'(req_ready), 64'b01);
        tick();
        clear_reqs();
        rst = 1'b1;
        set_req(1, 1'b1, 4, 1'b0, '0, '0);
        #1 chk("t5_rst_ready", 64'(req_ready), 64'd0);
        chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("t5_after_edge", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        clear_reqs();
        tick();

        // Conflict on bank 0, pointer restarts at port 0
        set_req(0, 1'b1, 0, 1'b0, '0, '0);
        set_req(1, 1'b1, 4, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("t4_gnt%0d", c), 64'(req_ready), 64'(conflict_gnt[c]));
            tick();
            chk($sformatf("t4_rsp%0d", c), 64'(rsp_valid), 64'(conflict_gnt[c]));
        end
        chk("t4_rdata0", 64'(rsp_rdata[0]), 64'h0A0A0A0A);
        chk("t4_rdata1", 64'(rsp_rdata[1]), 64'h44444444);
        clear_reqs();

        // Write ack at the top address, then read back
        set_req(1, 1'b1, 4095, 1'b1, 4'b1111, 32'hCAFEF00D);
        #1 chk("t6_wr_ready", 64'(req_ready), 64'b10);
        tick();
        chk("t6_ack_valid", 64'(rsp_valid), 64'b10);
        chk("t6_ack_data", 64'(rsp_rdata[1]), 64'd0);
        set_req(1, 1'b1, 4095, 1'b0, '0, '0);
        tick();
        chk("t6_rd_data", 64'(rsp_rdata[1]), 64'hCAFEF00D);
        clear_reqs();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
